// File: rtl/lcd_nibble_rx_if.sv
// LCD 4-bit bus: the driver side owns the pins and the receiver samples them.
interface lcd_nibble_rx_if;
  logic       rslcd;
  logic       rwlcd;
  logic       elcd;
  logic [3:0] lcdd;

  modport master (output rslcd, rwlcd, elcd, lcdd);
  modport slave  (input  rslcd, rwlcd, elcd, lcdd);
endinterface

// File: rtl/lcd_nibble_rx.sv
// HD44780-style 4-bit bus receiver: strobe detection, power-up tracking,
// nibble assembly and command/data decode into display state.
module lcd_nibble_rx #(
  parameter int unsigned E_MIN_HIGH = 8,
  parameter int unsigned BUSY_SHORT = 2000,
  parameter int unsigned BUSY_HOME  = 80000,
  parameter int unsigned BUSY_CLEAR = 82000
) (
  input  logic              CCLK,
  input  logic              reset,
  lcd_nibble_rx_if.slave    lcd,
  output logic              ready,
  output logic              busy,
  output logic              byte_valid,
  output logic [7:0]        byte_out,
  output logic              byte_is_data,
  output logic              char_we,
  output logic [6:0]        char_addr,
  output logic [7:0]        char_data,
  output logic              clear_pulse,
  output logic              disp_on,
  output logic              cursor_on,
  output logic              blink_on,
  output logic              two_line,
  output logic              frame_err,
  output logic              init_err,
  output logic              busy_viol
);

  localparam int unsigned BUSY_W = 17;
  localparam int unsigned ECNT_W = $clog2(E_MIN_HIGH + 1);

  typedef enum logic [2:0] {W3A, W3B, W3C, W2, HI, LO} state_t;

  // sync bit layout: [6]=rs [5]=rw [4]=e [3:0]=d
  logic [6:0]        sync1, sync2;
  logic              e_prev;
  logic [ECNT_W-1:0] ecnt;
  logic              lat_rs, lat_rw;
  logic [3:0]        lat_d;
  logic              strobe_c;

  state_t            state, state_n;
  logic [3:0]        hi_nib, hi_nib_n;
  logic              hi_rs, hi_rs_n;
  logic [6:0]        addr, addr_n;
  logic              id, id_n;
  logic [BUSY_W-1:0] busy_cnt, busy_n;
  logic              ready_n, disp_n, cursor_n, blink_n, two_n;
  logic              bv_n, bdata_n, we_n, clr_n, ferr_n, ierr_n, bviol_n;
  logic [7:0]        bout_n, cdata_n;
  logic [6:0]        caddr_n;
  logic [7:0]        byte_c;
  logic              done_c;

  // Two-flop synchronizer on all bus pins plus E edge history
  always_ff @(posedge CCLK or posedge reset) begin
    if (reset) begin
      sync1  <= '0;
      sync2  <= '0;
      e_prev <= 1'b0;
    end else begin
      sync1  <= {lcd.rslcd, lcd.rwlcd, lcd.elcd, lcd.lcdd};
      sync2  <= sync1;
      e_prev <= sync2[4];
    end
  end

  // E-high run length (saturating) and last E-high sample of rs/rw/d
  always_ff @(posedge CCLK or posedge reset) begin
    if (reset) begin
      ecnt   <= '0;
      lat_rs <= 1'b0;
      lat_rw <= 1'b0;
      lat_d  <= '0;
    end else if (sync2[4]) begin
      if (ecnt != ECNT_W'(E_MIN_HIGH)) ecnt <= ecnt + ECNT_W'(1);
      lat_rs <= sync2[6];
      lat_rw <= sync2[5];
      lat_d  <= sync2[3:0];
    end else begin
      ecnt <= '0;
    end
  end

  assign strobe_c = e_prev && !sync2[4] && (ecnt >= ECNT_W'(E_MIN_HIGH)) && !lat_rw;

  // Next-state, byte assembly and command/data decode
  always_comb begin
    state_n  = state;
    hi_nib_n = hi_nib;
    hi_rs_n  = hi_rs;
    addr_n   = addr;
    id_n     = id;
    busy_n   = (busy_cnt != '0) ? busy_cnt - BUSY_W'(1) : '0;
    ready_n  = ready;
    disp_n   = disp_on;
    cursor_n = cursor_on;
    blink_n  = blink_on;
    two_n    = two_line;
    bout_n   = byte_out;
    bdata_n  = byte_is_data;
    caddr_n  = char_addr;
    cdata_n  = char_data;
    bv_n     = 1'b0;
    we_n     = 1'b0;
    clr_n    = 1'b0;
    ferr_n   = 1'b0;
    ierr_n   = 1'b0;
    bviol_n  = 1'b0;
    done_c   = 1'b0;
    byte_c   = {hi_nib, lat_d};

    if (strobe_c) begin
      case (state)
        W3A, W3B, W3C: begin
          if (!lat_rs && lat_d == 4'h3) begin
            state_n = (state == W3A) ? W3B : (state == W3B) ? W3C : W2;
          end else begin
            ierr_n  = 1'b1;
            state_n = W3A;
          end
        end
        W2: begin
          if (lat_d == 4'h3) begin
            state_n = W2;
          end else if (!lat_rs && lat_d == 4'h2) begin
            state_n = HI;
            ready_n = 1'b1;
          end else begin
            ierr_n  = 1'b1;
            state_n = W3A;
          end
        end
        HI: begin
          bviol_n  = (busy_cnt != '0);
          hi_nib_n = lat_d;
          hi_rs_n  = lat_rs;
          state_n  = LO;
        end
        LO: begin
          bviol_n = (busy_cnt != '0);
          if (lat_rs == hi_rs) begin
            done_c  = 1'b1;
            state_n = HI;
          end else begin
            ferr_n   = 1'b1;
            hi_nib_n = lat_d;
            hi_rs_n  = lat_rs;
          end
        end
        default: state_n = W3A;
      endcase
    end

    if (done_c) begin
      bv_n    = 1'b1;
      bout_n  = byte_c;
      bdata_n = hi_rs;
      busy_n  = BUSY_W'(BUSY_SHORT);
      if (hi_rs) begin
        we_n    = 1'b1;
        caddr_n = addr;
        cdata_n = byte_c;
        addr_n  = id ? addr + 7'd1 : addr - 7'd1;
      end else begin
        casez (byte_c)
          8'b1???????: addr_n = byte_c[6:0];
          8'b01??????: ;
          8'b001?????: begin
            two_n = byte_c[3];
            if (byte_c[4]) begin
              state_n = W3A;
              ready_n = 1'b0;
            end
          end
          8'b0001????: ;
          8'b00001???: begin
            disp_n   = byte_c[2];
            cursor_n = byte_c[1];
            blink_n  = byte_c[0];
          end
          8'b000001??: id_n = byte_c[1];
          8'b0000001?: begin
            addr_n = '0;
            busy_n = BUSY_W'(BUSY_HOME);
          end
          8'b00000001: begin
            clr_n  = 1'b1;
            addr_n = '0;
            id_n   = 1'b1;
            busy_n = BUSY_W'(BUSY_CLEAR);
          end
          default: ;
        endcase
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge CCLK or posedge reset) begin
    if (reset) begin
      state        <= W3A;
      hi_nib       <= '0;
      hi_rs        <= 1'b0;
      addr         <= '0;
      id           <= 1'b1;
      busy_cnt     <= '0;
      ready        <= 1'b0;
      busy         <= 1'b0;
      byte_valid   <= 1'b0;
      byte_out     <= '0;
      byte_is_data <= 1'b0;
      char_we      <= 1'b0;
      char_addr    <= '0;
      char_data    <= '0;
      clear_pulse  <= 1'b0;
      disp_on      <= 1'b0;
      cursor_on    <= 1'b0;
      blink_on     <= 1'b0;
      two_line     <= 1'b0;
      frame_err    <= 1'b0;
      init_err     <= 1'b0;
      busy_viol    <= 1'b0;
    end else begin
      state        <= state_n;
      hi_nib       <= hi_nib_n;
      hi_rs        <= hi_rs_n;
      addr         <= addr_n;
      id           <= id_n;
      busy_cnt     <= busy_n;
      ready        <= ready_n;
      busy         <= (busy_n != '0);
      byte_valid   <= bv_n;
      byte_out     <= bout_n;
      byte_is_data <= bdata_n;
      char_we      <= we_n;
      char_addr    <= caddr_n;
      char_data    <= cdata_n;
      clear_pulse  <= clr_n;
      disp_on      <= disp_n;
      cursor_on    <= cursor_n;
      blink_on     <= blink_n;
      two_line     <= two_n;
      frame_err    <= ferr_n;
      init_err     <= ierr_n;
      busy_viol    <= bviol_n;
    end
  end

endmodule

// File: tb/tb_lcd_nibble_rx.sv
// Randomized bench for lcd_nibble_rx against a transaction-level LCD model.
module tb_lcd_nibble_rx;

  localparam int unsigned P_EMIN  = 8;
  localparam int unsigned P_SHORT = 40;
  localparam int unsigned P_HOME  = 300;
  localparam int unsigned P_CLEAR = 600;

  logic       CCLK;
  logic       reset;
  logic       ready, busy, byte_valid, byte_is_data, char_we, clear_pulse;
  logic       disp_on, cursor_on, blink_on, two_line, frame_err, init_err, busy_viol;
  logic [7:0] byte_out, char_data;
  logic [6:0] char_addr;

  lcd_nibble_rx_if bus ();

  lcd_nibble_rx #(
    .E_MIN_HIGH (P_EMIN),
    .BUSY_SHORT (P_SHORT),
    .BUSY_HOME  (P_HOME),
    .BUSY_CLEAR (P_CLEAR)
  ) dut (
    .CCLK         (CCLK),
    .reset        (reset),
    .lcd          (bus.slave),
    .ready        (ready),
    .busy         (busy),
    .byte_valid   (byte_valid),
    .byte_out     (byte_out),
    .byte_is_data (byte_is_data),
    .char_we      (char_we),
    .char_addr    (char_addr),
    .char_data    (char_data),
    .clear_pulse  (clear_pulse),
    .disp_on      (disp_on),
    .cursor_on    (cursor_on),
    .blink_on     (blink_on),
    .two_line     (two_line),
    .frame_err    (frame_err),
    .init_err     (init_err),
    .busy_viol    (busy_viol)
  );

  initial CCLK = 1'b0;
  always #5 CCLK = ~CCLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Observed side: pulses and busy-run lengths collected at negedge
  int got_bytes[$];
  int got_wr[$];
  int got_runs[$];
  int got_frame = 0, got_init = 0, got_viol = 0, got_clear = 0;
  int run = 0;

  always @(negedge CCLK) begin
    if (reset) begin
      run <= 0;
    end else begin
      if (byte_valid)  got_bytes.push_back(int'({byte_is_data, byte_out}));
      if (char_we)     got_wr.push_back(int'({char_addr, char_data}));
      if (frame_err)   got_frame <= got_frame + 1;
      if (init_err)    got_init  <= got_init + 1;
      if (busy_viol)   got_viol  <= got_viol + 1;
      if (clear_pulse) got_clear <= got_clear + 1;
      if (busy) run <= run + 1;
      else if (run != 0) begin
        got_runs.push_back(run);
        run <= 0;
      end
    end
  end

  // Reference model of the LCD controller, kept per transaction
  int exp_bytes[$];
  int exp_wr[$];
  int exp_runs[$];
  int exp_frame = 0, exp_init = 0, exp_viol = 0, exp_clear = 0;
  int m_ready, m_threes, m_pending, m_hi, m_hrs;
  int m_addr, m_id, m_disp, m_cur, m_blink, m_two;

  task automatic m_reset();
    m_ready = 0; m_threes = 0; m_pending = 0; m_hi = 0; m_hrs = 0;
    m_addr = 0; m_id = 1; m_disp = 0; m_cur = 0; m_blink = 0; m_two = 0;
  endtask

  task automatic m_complete(input int rs, input int b);
    int rl;
    rl = P_SHORT;
    exp_bytes.push_back(rs * 256 + b);
    if (rs != 0) begin
      exp_wr.push_back(m_addr * 256 + b);
      m_addr = (m_addr + ((m_id != 0) ? 1 : 127)) % 128;
    end else if (b >= 128) m_addr = b - 128;
    else if (b >= 64) begin end
    else if (b >= 32) begin
      m_two = (b / 8) % 2;
      if ((b / 16) % 2 == 1) begin
        m_ready = 0; m_threes = 0; m_pending = 0;
      end
    end
    else if (b >= 16) begin end
    else if (b >= 8) begin
      m_disp = (b / 4) % 2; m_cur = (b / 2) % 2; m_blink = b % 2;
    end
    else if (b >= 4) m_id = (b / 2) % 2;
    else if (b >= 2) begin m_addr = 0; rl = P_HOME; end
    else if (b == 1) begin m_addr = 0; m_id = 1; rl = P_CLEAR; exp_clear++; end
    exp_runs.push_back(rl);
  endtask

  task automatic m_nibble(input int rs, input int d, input int in_busy);
    if (m_ready == 0) begin
      if (m_threes < 3) begin
        if (rs == 0 && d == 3) m_threes++;
        else begin exp_init++; m_threes = 0; end
      end else if (d == 3) begin
      end else if (rs == 0 && d == 2) begin
        m_ready = 1; m_pending = 0;
      end else begin
        exp_init++; m_threes = 0;
      end
    end else begin
      if (in_busy != 0) exp_viol++;
      if (m_pending == 0) begin
        m_hi = d; m_hrs = rs; m_pending = 1;
      end else if (rs == m_hrs) begin
        m_pending = 0;
        m_complete(rs, m_hi * 16 + d);
      end else begin
        exp_frame++; m_hi = d; m_hrs = rs;
      end
    end
  endtask

  // Bus driver
  task automatic nib(input logic rs, input logic rw, input logic [3:0] d, input int hi);
    @(negedge CCLK);
    bus.rslcd = rs; bus.rwlcd = rw; bus.lcdd = d;
    @(negedge CCLK);
    bus.elcd = 1'b1;
    repeat (hi) @(negedge CCLK);
    bus.elcd = 1'b0;
    repeat (6) @(negedge CCLK);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < int'(P_CLEAR) + 100) begin
      @(negedge CCLK);
      k++;
    end
    if (busy) check_eq("busy_timeout", 1, 0);
  endtask

  task automatic send_nib(input logic rs, input logic [3:0] d, input int in_busy);
    if (in_busy == 0) wait_idle();
    m_nibble(int'(rs), int'(d), in_busy);
    nib(rs, 1'b0, d, 32);
  endtask

  task automatic send_byte(input logic rs, input logic [7:0] b);
    send_nib(rs, b[7:4], 0);
    send_nib(rs, b[3:0], 0);
  endtask

  task automatic do_init();
    send_nib(1'b0, 4'h3, 0);
    send_nib(1'b0, 4'h3, 0);
    send_nib(1'b0, 4'h3, 0);
    send_nib(1'b0, 4'h2, 0);
  endtask

  task automatic check_all(input string tag);
    wait_idle();
    repeat (4) @(negedge CCLK);
    check_eq({tag, ":nbytes"}, got_bytes.size(), exp_bytes.size());
    while (got_bytes.size() > 0 && exp_bytes.size() > 0)
      check_eq({tag, ":byte"}, got_bytes.pop_front(), exp_bytes.pop_front());
    check_eq({tag, ":nwr"}, got_wr.size(), exp_wr.size());
    while (got_wr.size() > 0 && exp_wr.size() > 0)
      check_eq({tag, ":wr"}, got_wr.pop_front(), exp_wr.pop_front());
    check_eq({tag, ":nruns"}, got_runs.size(), exp_runs.size());
    while (got_runs.size() > 0 && exp_runs.size() > 0)
      check_eq({tag, ":busyrun"}, got_runs.pop_front(), exp_runs.pop_front());
    got_bytes.delete(); exp_bytes.delete();
    got_wr.delete();    exp_wr.delete();
    got_runs.delete();  exp_runs.delete();
    check_eq({tag, ":ready"},     int'(ready),     m_ready);
    check_eq({tag, ":two_line"},  int'(two_line),  m_two);
    check_eq({tag, ":disp_on"},   int'(disp_on),   m_disp);
    check_eq({tag, ":cursor_on"}, int'(cursor_on), m_cur);
    check_eq({tag, ":blink_on"},  int'(blink_on),  m_blink);
    check_eq({tag, ":frame_err"}, got_frame, exp_frame);
    check_eq({tag, ":init_err"},  got_init,  exp_init);
    check_eq({tag, ":busy_viol"}, got_viol,  exp_viol);
    check_eq({tag, ":clear"},     got_clear, exp_clear);
  endtask

  task automatic check_reset_outs(input string tag);
    check_eq({tag, ":ready"},   int'(ready), 0);
    check_eq({tag, ":busy"},    int'(busy), 0);
    check_eq({tag, ":bvalid"},  int'(byte_valid), 0);
    check_eq({tag, ":byteout"}, int'(byte_out), 0);
    check_eq({tag, ":disp"},    int'({disp_on, cursor_on, blink_on, two_line}), 0);
    check_eq({tag, ":pulses"},  int'({char_we, clear_pulse, frame_err, init_err, busy_viol}), 0);
  endtask

  initial begin
    logic [7:0] b;
    int sel;
    bus.rslcd = 1'b0; bus.rwlcd = 1'b0; bus.elcd = 1'b0; bus.lcdd = 4'h0;
    reset = 1'b1;
    m_reset();
    repeat (3) @(negedge CCLK);
    check_reset_outs("rst");
    reset = 1'b0;

    // Driver power-up and basic configuration
    do_init();
    send_byte(1'b0, 8'h28);
    send_byte(1'b0, 8'h06);
    send_byte(1'b0, 8'h0C);
    check_all("init");

    send_byte(1'b1, 8'h41);
    send_byte(1'b1, 8'h42);
    check_all("data2");

    // Address set then decrement
    send_byte(1'b0, 8'h04);
    send_byte(1'b0, 8'hC5);
    send_byte(1'b1, 8'h30);
    send_byte(1'b1, 8'h31);
    check_all("decr");

    // Address wrap at 0x7F
    send_byte(1'b0, 8'h06);
    send_byte(1'b0, 8'hFF);
    send_byte(1'b1, 8'h55);
    send_byte(1'b1, 8'h56);
    check_all("wrap");

    // Clear, then a nibble while still busy
    send_byte(1'b0, 8'h01);
    repeat (100) @(negedge CCLK);
    send_nib(1'b1, 4'h7, 1);
    send_nib(1'b1, 4'h3, 0);
    check_all("clear");

    // Short E pulse and a read strobe between two nibbles
    send_nib(1'b1, 4'h5, 0);
    nib(1'b0, 1'b0, 4'h9, 4);
    nib(1'b0, 1'b1, 4'h9, 32);
    send_nib(1'b1, 4'hA, 0);
    check_all("ignore");

    // rs mismatch between nibbles
    send_nib(1'b0, 4'h4, 0);
    send_nib(1'b1, 4'h6, 0);
    send_nib(1'b1, 4'h1, 0);
    check_all("frame");

    // Randomized command/data traffic
    for (int i = 0; i < 24; i++) begin
      if (m_ready == 0) do_init();
      sel = int'($urandom_range(0, 9));
      b = 8'($urandom);
      case (sel)
        0, 1, 2, 3: send_byte(1'b1, b);
        4: send_byte(1'b0, {1'b1, b[6:0]});
        5: send_byte(1'b0, {4'b0000, 1'b1, b[2:0]});
        6: send_byte(1'b0, {5'b00000, 1'b1, b[1:0]});
        7: send_byte(1'b0, {3'b001, b[4:0]});
        8: send_byte(1'b0, {2'b01, b[5:0]});
        default: send_byte(1'b0, {6'b000000, 1'b1, b[0]});
      endcase
      check_all("rand");
    end
    if (m_ready == 0) do_init();

    // Reset mid-busy and mid-byte
    send_byte(1'b0, 8'h02);
    send_nib(1'b1, 4'h4, 1);
    @(negedge CCLK);
    reset = 1'b1;
    #1;
    check_reset_outs("midrst");
    m_reset();
    got_runs.delete();
    exp_runs.delete();
    repeat (3) @(negedge CCLK);
    reset = 1'b0;
    check_all("postrst");
    do_init();
    send_byte(1'b1, 8'h5A);
    check_all("reinit");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout got=0 exp=1");
    $fatal(1, "timeout");
  end

endmodule
